threshold_block_reader: RTL and testbench

- Read-side counterpart of the threshold cutter's block writer. On a read-start pulse carrying a block base address, it issues AXI4 INCR read bursts against the window BRAM's read port and fetches one complete cut block (BLOCK_DEPTH entries of 32 B).
- It streams the block out on a valid/ready interface toward the PS/DMA path, marking the last entry.
- An internal FIFO absorbs downstream backpressure.

---
 rtl/threshold_pkg.sv | 9 +
 rtl/sync_fifo.sv | 35 +++
 rtl/threshold_block_reader.sv | 101 ++++++++++
 tb/tb_threshold_block_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/threshold_pkg.sv
// threshold_pkg: shared constants and FSM state type for the threshold cutter block path
package threshold_pkg;
  localparam int BLOCK_DEPTH = 400;
  localparam int ADDR_STRIDE = 1;
  localparam logic [2:0] ARSIZE_32B = 3'b101;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word fall-through head and occupancy count
module sync_fifo #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH_INDEX = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [DEPTH_INDEX:0]  count,
  output logic                  empty
);
  localparam logic [DEPTH_INDEX:0] DEPTH = {1'b1, {DEPTH_INDEX{1'b0}}};
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_INDEX];
  logic [DEPTH_INDEX-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == 0;
  assign do_pop = pop && !empty;
  assign do_push = push && (count != DEPTH || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1;
      if (do_pop) rd_ptr <= rd_ptr + 1;
      count <= (do_push && !do_pop) ? count + 1 : (!do_push && do_pop) ? count - 1 : count;
    end
endmodule

// File: rtl/threshold_block_reader.sv
// threshold_block_reader: fetches one cut block from the window BRAM over AXI4 INCR bursts
// and streams it out on valid/ready, reserving FIFO space before each burst is issued.
module threshold_block_reader #(
  parameter int BLOCK_DEPTH = threshold_pkg::BLOCK_DEPTH,
  parameter int BURST_LEN = 16,
  parameter int FIFO_DEPTH_INDEX = 5,
  parameter int ADDR_STRIDE = threshold_pkg::ADDR_STRIDE,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_start,
  input  logic [31:0]           read_araddr_start,
  output logic                  busy,
  output logic                  start_dropped,
  output logic                  rd_err,
  output logic [3:0]            m_axi_arid,
  output logic [31:0]           m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [3:0]            m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);
  import threshold_pkg::*;
  localparam int FIFO_DEPTH = 2**FIFO_DEPTH_INDEX;
  state_t state, next;
  logic [31:0] addr_r, beats_left, out_cnt, reserved, burst, free;
  logic [FIFO_DEPTH_INDEX:0] count;
  logic empty, push, pop, ar_fire;
  assign burst = beats_left < 32'(BURST_LEN) ? beats_left : 32'(BURST_LEN);
  // Beats already granted an AR but not yet landed still own their FIFO slots.
  assign free = 32'(FIFO_DEPTH) - 32'(count) - reserved;
  assign m_axi_arid = '0;
  assign m_axi_arsize = ARSIZE_32B;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_araddr = addr_r;
  assign m_axi_arlen = state == ADDR ? 8'(burst - 1) : 8'd0;
  assign m_axi_arvalid = state == ADDR && free >= burst;
  assign ar_fire = m_axi_arvalid && m_axi_arready;
  // IDLE keeps rready high so beats left over from an aborted block are swallowed.
  assign m_axi_rready = rst_n && (state == IDLE || state == DATA);
  assign push = state == DATA && m_axi_rvalid;
  assign m_valid = !empty;
  assign pop = m_valid && m_ready;
  assign m_last = m_valid && out_cnt == 32'(BLOCK_DEPTH - 1);
  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_INDEX(FIFO_DEPTH_INDEX)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .din(m_axi_rdata), .pop(pop),
    .dout(m_data), .count(count), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:  next = read_start ? ADDR : IDLE;
      ADDR:  next = ar_fire ? DATA : ADDR;
      DATA:  next = (push && m_axi_rlast) ? (beats_left != 0 ? ADDR : DRAIN) : DATA;
      DRAIN: next = (pop && m_last) ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_r <= '0;
      beats_left <= '0;
      out_cnt <= '0;
      reserved <= '0;
      busy <= 1'b0;
      start_dropped <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      start_dropped <= read_start && busy;
      if (state == IDLE && read_start) begin
        addr_r <= read_araddr_start;
        beats_left <= 32'(BLOCK_DEPTH);
        out_cnt <= '0;
        rd_err <= 1'b0;
        busy <= 1'b1;
      end else begin
        if (pop) out_cnt <= out_cnt + 1;
        if (push && (m_axi_rresp != RESP_OKAY || m_axi_rid != '0)) rd_err <= 1'b1;
        if (state == DRAIN && pop && m_last) busy <= 1'b0;
        if (ar_fire) begin
          addr_r <= addr_r + burst * ADDR_STRIDE;
          beats_left <= beats_left - burst;
        end
      end
      reserved <= reserved + (ar_fire ? burst : 32'd0) - 32'(push);
    end
endmodule

// File: tb/tb_threshold_block_reader.sv
// tb_threshold_block_reader: scoreboard bench with a reactive AXI read slave and output sink
module tb_threshold_block_reader;
  localparam int DEPTH = 40;
  localparam int BL = 16;
  localparam int DW = 256;
  logic clk = 1'b0, rst_n = 1'b0, read_start = 1'b0;
  logic [31:0] read_araddr_start = '0;
  logic busy, start_dropped, rd_err, arvalid, rready, m_valid, m_last;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [DW-1:0] m_data;
  logic arready = 1'b0, rlast = 1'b0, rvalid = 1'b0, m_ready = 1'b1;
  logic [3:0] rid = '0;
  logic [1:0] rresp = '0;
  logic [DW-1:0] rdata = '0;

  threshold_block_reader #(.BLOCK_DEPTH(DEPTH), .BURST_LEN(BL), .FIFO_DEPTH_INDEX(5), .ADDR_STRIDE(1), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .read_start(read_start), .read_araddr_start(read_araddr_start),
    .busy(busy), .start_dropped(start_dropped), .rd_err(rd_err),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW:0] exp_q[$];
  logic [39:0] ar_q[$];
  logic [39:0] sl_q[$];
  int sl_beat = 0, blk_beat = 0, err_beat = -1, stall_cnt = 0, stall_seen = 0;
  bit bp = 0, last_seen = 0, prev_pend = 0;
  longint issued = 0, popped = 0;
  logic [31:0] prev_addr;
  logic [7:0] prev_len;

  // Slave, sink and scoreboard: drive at negedge, judge the coming posedge 1 time unit later.
  initial begin
    logic [31:0] a;
    logic [39:0] e40;
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      m_ready = bp ? ($urandom_range(0, 3) == 0) : 1'b1;
      arready = stall_cnt == 0;
      if (sl_q.size() != 0) begin
        a = sl_q[0][39:8] + sl_beat;
        rvalid = 1'b1;
        rdata = {8{a}};
        rlast = sl_beat == int'(sl_q[0][7:0]);
        rresp = blk_beat == err_beat ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0;
        rlast = 1'b0;
        rresp = 2'b00;
        rdata = '0;
      end
      #1;
      if (!rst_n) prev_pend = 0;
      else begin
        if (prev_pend) begin
          check("ar_hold_valid", arvalid, 1'b1);
          check("ar_hold_addr", araddr, prev_addr);
          check("ar_hold_len", arlen, prev_len);
        end
        if (arvalid) begin
          check("ar_space", issued - popped + longint'(arlen) + 1 <= 32, 1'b1);
          if (arready) begin
            check("ar_expected", ar_q.size() != 0, 1'b1);
            check("ar_consts", {arid, arsize, arburst}, {4'd0, 3'b101, 2'b01});
            if (ar_q.size() != 0) begin
              e40 = ar_q.pop_front();
              check("araddr", araddr, e40[39:8]);
              check("arlen", arlen, e40[7:0]);
            end
            sl_q.push_back({araddr, arlen});
            issued += longint'(arlen) + 1;
          end else if (stall_cnt > 0) begin
            stall_cnt--;
            stall_seen++;
          end
        end
        prev_pend = arvalid && !arready;
        prev_addr = araddr;
        prev_len = arlen;
        if (rvalid) begin
          check("rready", rready, 1'b1);
          if (rready) begin
            blk_beat++;
            if (rlast) begin
              void'(sl_q.pop_front());
              sl_beat = 0;
            end else sl_beat++;
          end
        end
        if (last_seen) begin
          check("busy_after_last", busy, 1'b0);
          last_seen = 0;
        end
        if (m_valid && m_ready) begin
          check("out_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("m_data", m_data, e[DW-1:0]);
            check("m_last", m_last, e[DW]);
            popped++;
            if (e[DW]) begin
              check("busy_at_last", busy, 1'b1);
              last_seen = 1;
            end
          end
        end
      end
    end
  end

  task automatic start_block(input logic [31:0] base);
    logic [31:0] a;
    @(negedge clk);
    read_start = 1'b1;
    read_araddr_start = base;
    exp_q.delete();
    ar_q.delete();
    issued = 0;
    popped = 0;
    blk_beat = 0;
    stall_seen = 0;
    for (int i = 0; i < DEPTH; i++) begin
      a = base + i;
      exp_q.push_back({i == DEPTH - 1, {8{a}}});
    end
    for (int i = 0; i < DEPTH; i += BL) begin
      a = base + i;
      ar_q.push_back({a, 8'(((DEPTH - i) < BL ? DEPTH - i : BL) - 1)});
    end
    @(negedge clk);
    read_start = 1'b0;
    #1;
    check("busy_rise", busy, 1'b1);
    check("arvalid_first", arvalid, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    #2;
    check({tag, "_timeout"}, busy, 1'b0);
    check({tag, "_outputs_left"}, exp_q.size(), 0);
    check({tag, "_ars_left"}, ar_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_dropped"}, start_dropped, 1'b0);
    check({tag, "_rd_err"}, rd_err, 1'b0);
    check({tag, "_arvalid"}, arvalid, 1'b0);
    check({tag, "_araddr"}, araddr, 32'd0);
    check({tag, "_arlen"}, arlen, 8'd0);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_m_last"}, m_last, 1'b0);
    check({tag, "_rready"}, rready, 1'b0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    start_block(32'h0000_2000);
    wait_idle("basic");
    check("basic_rd_err", rd_err, 1'b0);

    stall_cnt = 5;
    start_block(32'hFFFF_FFF8);
    wait_idle("stall_wrap");
    check("stall_cycles", stall_seen, 5);

    bp = 1;
    start_block(32'h0004_0000);
    wait_idle("backpressure");
    bp = 0;

    err_beat = 7;
    start_block(32'h0000_3000);
    repeat (6) @(negedge clk);
    read_start = 1'b1;
    read_araddr_start = 32'h0000_9000;
    @(negedge clk);
    read_start = 1'b0;
    #1;
    check("start_dropped_pulse", start_dropped, 1'b1);
    @(negedge clk);
    #1;
    check("start_dropped_clear", start_dropped, 1'b0);
    wait_idle("error");
    check("rd_err_set", rd_err, 1'b1);
    err_beat = -1;
    repeat (5) @(negedge clk);
    check("rd_err_sticky", rd_err, 1'b1);

    err_beat = 2;
    start_block(32'h0000_5000);
    n = 0;
    while (blk_beat < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_beat5", blk_beat >= 5, 1'b1);
    check("rd_err_pre_reset", rd_err, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    ar_q.delete();
    err_beat = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (sl_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    #2;
    check("leftovers_drained", sl_q.size(), 0);
    check("leftovers_discarded", m_valid, 1'b0);
    start_block(32'h0000_6000);
    wait_idle("post_reset");
    check("post_reset_rd_err", rd_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
